// File: rtl/pixel_fetcher_pkg.sv
// Shared definitions for the pixel fetcher: command field layout, opcodes and FSM encoding.
package pixel_fetcher_pkg;

    localparam int CMD_WIDTH   = 128;
    localparam int OPC_LSB     = 0;
    localparam int OPC_MSB     = 3;
    localparam int TAG_LSB     = 4;
    localparam int TAG_MSB     = 19;
    localparam int CNT_LSB     = 20;
    localparam int CNT_MSB     = 55;
    localparam int ADDR_LSB    = 56;
    localparam int ADDR_MSB    = 91;

    localparam int TAG_WIDTH   = TAG_MSB - TAG_LSB + 1;
    localparam int CNT_WIDTH   = CNT_MSB - CNT_LSB + 1;
    localparam int CADDR_WIDTH = ADDR_MSB - ADDR_LSB + 1;
    localparam int WORDS_WIDTH = CNT_WIDTH + 1;

    localparam logic [3:0] OPC_FETCH = 4'b0111;
    localparam logic [3:0] OPC_STORE = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [CADDR_WIDTH-1:0] addr;
        logic [CNT_WIDTH-1:0]   count;
        logic [TAG_WIDTH-1:0]   tag;
        logic [3:0]             opcode;
    } fetch_cmd_t;

    function automatic fetch_cmd_t decode_cmd(input logic [CMD_WIDTH-1:0] raw);
        fetch_cmd_t c;
        c.opcode = raw[OPC_MSB:OPC_LSB];
        c.tag    = raw[TAG_MSB:TAG_LSB];
        c.count  = raw[CNT_MSB:CNT_LSB];
        c.addr   = raw[ADDR_MSB:ADDR_LSB];
        return c;
    endfunction

endpackage

// File: rtl/pixel_fetcher_fifo.sv
// fetch_fifo: synchronous return-data buffer with occupancy count; head word is
// presented combinationally so it stays stable until popped.
module fetch_fifo #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // NOTE: storage carries no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/pixel_fetcher.sv
// pixel_fetcher: read-DMA engine; one fetch command becomes in-order word reads streamed out.
// Optional macro PIXEL_FETCHER_CHECK_EN enables opcode checking and the sticky cmd_error flag.
module pixel_fetcher
    import pixel_fetcher_pkg::*;
#(
    parameter int ADDRESS_SIZE = 36,
    parameter int DATA_WIDTH   = 128,
    parameter int PIXEL_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CMD_WIDTH-1:0]    fetcher_command,
    input  logic                    fetcher_command_valid,
    output logic                    fetcher_command_complete,
    output logic [TAG_WIDTH-1:0]    fetcher_tag,
    output logic [ADDRESS_SIZE-1:0] master_address,
    output logic                    master_rdreq,
    input  logic                    master_rdack,
    input  logic [DATA_WIDTH-1:0]   master_rdata,
    input  logic                    master_rvalid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    cmd_error
);

    localparam int PPW            = DATA_WIDTH / PIXEL_WIDTH;
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int OFS_W          = $clog2(BYTES_PER_WORD);
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORDS_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [WORDS_WIDTH-1:0]  pop_left_q, pop_left_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic                    complete_q, complete_d;

    fetch_cmd_t              cmd;
    logic [ADDRESS_SIZE-1:0] cmd_addr;
    logic [ADDRESS_SIZE-1:0] cmd_addr_aligned;
    logic [WORDS_WIDTH-1:0]  cmd_words;
    logic                    cmd_ok;
    logic                    rdreq;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        credits;
    logic                    unused_bits;

    assign cmd              = decode_cmd(fetcher_command);
    assign cmd_addr         = ADDRESS_SIZE'(cmd.addr);
    assign cmd_addr_aligned = {cmd_addr[ADDRESS_SIZE-1:OFS_W], OFS_W'(0)};
    assign cmd_words        = (WORDS_WIDTH'(cmd.count) + WORDS_WIDTH'(PPW - 1)) / WORDS_WIDTH'(PPW);

    // Every in-flight read already owns a FIFO slot, so responses can never overflow it.
    assign credits = CNT_W'(FIFO_DEPTH) - (fifo_count + outstanding_q);
    assign push    = master_rvalid && (outstanding_q != '0);
    assign pop     = out_valid && out_ready;

`ifdef PIXEL_FETCHER_CHECK_EN
    logic cmd_error_q;

    assign cmd_ok = (cmd.opcode == OPC_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_error_q <= 1'b0;
        end else if (fetcher_command_valid && ((state_q != ST_IDLE) || !cmd_ok)) begin
            cmd_error_q <= 1'b1;
        end
    end

    assign cmd_error   = cmd_error_q;
    assign unused_bits = ^{fetcher_command[CMD_WIDTH-1:ADDR_MSB+1], cmd_addr[OFS_W-1:0]};
`else
    assign cmd_ok      = 1'b1;
    assign cmd_error   = 1'b0;
    assign unused_bits = ^{fetcher_command[CMD_WIDTH-1:ADDR_MSB+1], cmd_addr[OFS_W-1:0], cmd.opcode};
`endif

    always_comb begin
        // NOTE: all block outputs get a default first, so no branch can leave one unassigned (no latches).
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        tag_d        = tag_q;
        complete_d   = complete_q;
        rdreq        = 1'b0;

        if (pop) pop_left_d = pop_left_q - WORDS_WIDTH'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (fetcher_command_valid && cmd_ok) begin
                    tag_d  = cmd.tag;
                    addr_d = cmd_addr_aligned;
                    if (cmd_words != '0) begin
                        issue_left_d = cmd_words;
                        pop_left_d   = cmd_words;
                        complete_d   = 1'b0;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                rdreq = (issue_left_q != '0) && (credits != '0);
                if (rdreq && master_rdack) begin
                    addr_d       = addr_q + ADDRESS_SIZE'(BYTES_PER_WORD);
                    issue_left_d = issue_left_q - WORDS_WIDTH'(1);
                    if (issue_left_q == WORDS_WIDTH'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_left_q == '0) begin
                    state_d    = ST_IDLE;
                    complete_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        outstanding_d = outstanding_q + CNT_W'(rdreq && master_rdack) - CNT_W'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            issue_left_q  <= '0;
            pop_left_q    <= '0;
            outstanding_q <= '0;
            tag_q         <= '0;
            complete_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            issue_left_q  <= issue_left_d;
            pop_left_q    <= pop_left_d;
            outstanding_q <= outstanding_d;
            tag_q         <= tag_d;
            complete_q    <= complete_d;
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (master_rdata),
        .pop_i   (pop),
        .rdata_o (out_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid                = !fifo_empty;
    assign out_last                 = out_valid && (pop_left_q == WORDS_WIDTH'(1));
    assign master_rdreq             = rdreq;
    assign master_address           = addr_q;
    assign fetcher_tag              = tag_q;
    assign fetcher_command_complete = complete_q;

endmodule

// File: tb/tb_pixel_fetcher.sv
// Directed self-checking bench for pixel_fetcher: behavioural memory slave, stream sink,
// and one task per scenario with hand-computed expectations.
module tb_pixel_fetcher;
    import pixel_fetcher_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] fetcher_command;
    logic         fetcher_command_valid;
    logic         fetcher_command_complete;
    logic [15:0]  fetcher_tag;
    logic [35:0]  master_address;
    logic         master_rdreq;
    logic         master_rdack;
    logic [127:0] master_rdata;
    logic         master_rvalid;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         cmd_error;

    int checks   = 0;
    int failures = 0;

    logic [35:0]  acc_q[$];
    logic [35:0]  resp_q[$];
    logic [127:0] rx_data_q[$];
    logic         rx_last_q[$];
    int           ack_delay       = 1;
    int           wait_cnt        = 0;
    int           hold_violations = 0;
    int           stale_cnt       = 0;
    int           stale_done      = 0;
    bit           held            = 1'b0;
    logic [35:0]  held_addr;

    pixel_fetcher dut (
        .clk                      (clk),
        .rst                      (rst),
        .fetcher_command          (fetcher_command),
        .fetcher_command_valid    (fetcher_command_valid),
        .fetcher_command_complete (fetcher_command_complete),
        .fetcher_tag              (fetcher_tag),
        .master_address           (master_address),
        .master_rdreq             (master_rdreq),
        .master_rdack             (master_rdack),
        .master_rdata             (master_rdata),
        .master_rvalid            (master_rvalid),
        .out_data                 (out_data),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_last                 (out_last),
        .cmd_error                (cmd_error)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] data_for(input logic [35:0] a);
        return {32'hDA7A_5EED, 28'h0, a, a[35:4]};
    endfunction

    // Memory slave: acks after ack_delay waiting cycles, returns data one cycle after the ack.
    always @(negedge clk) begin
        if (stale_cnt != stale_done) begin
            master_rvalid = 1'b1;
            master_rdata  = {4{32'hBAD0_BAD0}};
            stale_done++;
        end else if (resp_q.size() > 0) begin
            master_rvalid = 1'b1;
            master_rdata  = data_for(resp_q.pop_front());
        end else begin
            master_rvalid = 1'b0;
        end
        if (master_rdreq) begin
            if (held && (master_address !== held_addr)) hold_violations++;
            if (wait_cnt >= ack_delay) begin
                master_rdack = 1'b1;
                acc_q.push_back(master_address);
                resp_q.push_back(master_address);
                wait_cnt = 0;
                held     = 1'b0;
            end else begin
                master_rdack = 1'b0;
                wait_cnt++;
                held      = 1'b1;
                held_addr = master_address;
            end
        end else begin
            master_rdack = 1'b0;
            wait_cnt     = 0;
            held         = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rx_data_q.push_back(out_data);
            rx_last_q.push_back(out_last);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic send_cmd(input logic [35:0] addr, input logic [35:0] count,
                            input logic [15:0] tag, input logic [3:0] opc);
        @(posedge clk); #1;
        fetcher_command       = {36'h0, addr, count, tag, opc};
        fetcher_command_valid = 1'b1;
        @(posedge clk); #1;
        fetcher_command_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fetcher_command_complete === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fetcher_command_complete !== 1'b1) begin failures++; $display("FAIL reset_complete: got %b want 1", fetcher_command_complete); end
        checks++; if (master_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq: got %b want 0", master_rdreq); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (fetcher_tag !== 16'h0) begin failures++; $display("FAIL reset_tag: got %h want 0", fetcher_tag); end
        checks++; if (master_address !== 36'h0) begin failures++; $display("FAIL reset_address: got %h want 0", master_address); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL reset_cmd_error: got %b want 0", cmd_error); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int acc_base, rx_base;
        bit to;
        logic [35:0] ea;
        ack_delay = 1; out_ready = 1'b1;
        acc_base = acc_q.size(); rx_base = rx_data_q.size();
        send_cmd(36'h100, 36'd16, 16'hBEEF, OPC_FETCH);
        checks++; if (master_rdreq !== 1'b1) begin failures++; $display("FAIL basic_rdreq_latency: got %b want 1", master_rdreq); end
        checks++; if (master_address !== 36'h100) begin failures++; $display("FAIL basic_first_addr: got %h want 100", master_address); end
        checks++; if (fetcher_command_complete !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b want 0", fetcher_command_complete); end
        checks++; if (fetcher_tag !== 16'hBEEF) begin failures++; $display("FAIL basic_tag: got %h want beef", fetcher_tag); end
        wait_idle(200, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout: complete got 0 want 1"); end
        checks++; if (acc_q.size() - acc_base != 4) begin failures++; $display("FAIL basic_reads: got %0d want 4", acc_q.size() - acc_base); end
        checks++; if (rx_data_q.size() - rx_base != 4) begin failures++; $display("FAIL basic_words: got %0d want 4", rx_data_q.size() - rx_base); end
        for (int i = 0; i < 4; i++) begin
            ea = 36'h100 + 36'(16 * i);
            checks++; if (acc_q[acc_base+i] !== ea) begin failures++; $display("FAIL basic_addr%0d: got %h want %h", i, acc_q[acc_base+i], ea); end
            checks++; if (rx_data_q[rx_base+i] !== data_for(ea)) begin failures++; $display("FAIL basic_data%0d: got %h want %h", i, rx_data_q[rx_base+i], data_for(ea)); end
            checks++; if (rx_last_q[rx_base+i] !== (i == 3)) begin failures++; $display("FAIL basic_last%0d: got %b want %b", i, rx_last_q[rx_base+i], (i == 3)); end
        end
        checks++; if (hold_violations != 0) begin failures++; $display("FAIL basic_addr_hold: got %0d changes want 0", hold_violations); end
    endtask

    task automatic test_ceil_count();
        int acc_base, rx_base;
        bit to;
        logic [35:0] ea;
        ack_delay = 1; out_ready = 1'b1;
        acc_base = acc_q.size(); rx_base = rx_data_q.size();
        send_cmd(36'h2008, 36'd5, 16'h0002, OPC_FETCH);
        wait_idle(200, to);
        checks++; if (to) begin failures++; $display("FAIL ceil_timeout: complete got 0 want 1"); end
        checks++; if (acc_q.size() - acc_base != 2) begin failures++; $display("FAIL ceil_reads: got %0d want 2", acc_q.size() - acc_base); end
        checks++; if (rx_data_q.size() - rx_base != 2) begin failures++; $display("FAIL ceil_words: got %0d want 2", rx_data_q.size() - rx_base); end
        for (int i = 0; i < 2; i++) begin
            ea = 36'h2000 + 36'(16 * i);
            checks++; if (acc_q[acc_base+i] !== ea) begin failures++; $display("FAIL ceil_addr%0d: got %h want %h", i, acc_q[acc_base+i], ea); end
            checks++; if (rx_last_q[rx_base+i] !== (i == 1)) begin failures++; $display("FAIL ceil_last%0d: got %b want %b", i, rx_last_q[rx_base+i], (i == 1)); end
        end
    endtask

    task automatic test_backpressure();
        int acc_base, rx_base;
        bit to;
        logic [35:0]  ea;
        logic [127:0] head0;
        ack_delay = 0; out_ready = 1'b0;
        acc_base = acc_q.size(); rx_base = rx_data_q.size();
        send_cmd(36'h4000, 36'd64, 16'h0003, OPC_FETCH);
        repeat (30) @(posedge clk);
        #1;
        checks++; if (acc_q.size() - acc_base != 8) begin failures++; $display("FAIL bp_credit_reads: got %0d want 8", acc_q.size() - acc_base); end
        checks++; if (master_rdreq !== 1'b0) begin failures++; $display("FAIL bp_rdreq_low: got %b want 0", master_rdreq); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        head0 = out_data;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (head0 !== data_for(36'h4000)) begin failures++; $display("FAIL bp_head: got %h want %h", head0, data_for(36'h4000)); end
        checks++; if (out_data !== data_for(36'h4000)) begin failures++; $display("FAIL bp_head_stable: got %h want %h", out_data, data_for(36'h4000)); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL bp_last_early: got %b want 0", out_last); end
        out_ready = 1'b1;
        wait_idle(400, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout: complete got 0 want 1"); end
        checks++; if (acc_q.size() - acc_base != 16) begin failures++; $display("FAIL bp_reads: got %0d want 16", acc_q.size() - acc_base); end
        checks++; if (rx_data_q.size() - rx_base != 16) begin failures++; $display("FAIL bp_words: got %0d want 16", rx_data_q.size() - rx_base); end
        for (int i = 0; i < 16; i++) begin
            ea = 36'h4000 + 36'(16 * i);
            checks++; if (rx_data_q[rx_base+i] !== data_for(ea)) begin failures++; $display("FAIL bp_data%0d: got %h want %h", i, rx_data_q[rx_base+i], data_for(ea)); end
            checks++; if (rx_last_q[rx_base+i] !== (i == 15)) begin failures++; $display("FAIL bp_last%0d: got %b want %b", i, rx_last_q[rx_base+i], (i == 15)); end
        end
    endtask

    task automatic test_addr_wrap();
        int acc_base, rx_base;
        bit to;
        ack_delay = 1; out_ready = 1'b1;
        acc_base = acc_q.size(); rx_base = rx_data_q.size();
        send_cmd(36'hF_FFFF_FFF0, 36'd8, 16'h0004, OPC_FETCH);
        wait_idle(200, to);
        checks++; if (to) begin failures++; $display("FAIL wrap_timeout: complete got 0 want 1"); end
        checks++; if (acc_q[acc_base] !== 36'hF_FFFF_FFF0) begin failures++; $display("FAIL wrap_addr0: got %h want ffffffff0", acc_q[acc_base]); end
        checks++; if (acc_q[acc_base+1] !== 36'h0) begin failures++; $display("FAIL wrap_addr1: got %h want 000000000", acc_q[acc_base+1]); end
        checks++; if (rx_data_q[rx_base+1] !== data_for(36'h0)) begin failures++; $display("FAIL wrap_data1: got %h want %h", rx_data_q[rx_base+1], data_for(36'h0)); end
        checks++; if (hold_violations != 0) begin failures++; $display("FAIL wrap_addr_hold: got %0d changes want 0", hold_violations); end
    endtask

    task automatic test_zero_and_busy();
        int acc_base, rx_base;
        bit to, saw_req, saw_valid, saw_busy;
        ack_delay = 1; out_ready = 1'b1;
        acc_base = acc_q.size(); rx_base = rx_data_q.size();
        send_cmd(36'h3000, 36'd0, 16'h0005, OPC_FETCH);
        saw_req = 1'b0; saw_valid = 1'b0; saw_busy = 1'b0;
        repeat (8) begin
            if (master_rdreq) saw_req = 1'b1;
            if (out_valid) saw_valid = 1'b1;
            if (!fetcher_command_complete) saw_busy = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_req) begin failures++; $display("FAIL zero_rdreq: got 1 want 0"); end
        checks++; if (saw_valid) begin failures++; $display("FAIL zero_out_valid: got 1 want 0"); end
        checks++; if (saw_busy) begin failures++; $display("FAIL zero_complete: got 0 want 1"); end
        send_cmd(36'h5000, 36'd8, 16'h0A0A, OPC_FETCH);
        send_cmd(36'h6000, 36'd40, 16'h0B0B, OPC_FETCH);
        wait_idle(200, to);
        checks++; if (to) begin failures++; $display("FAIL busy_timeout: complete got 0 want 1"); end
        saw_req = 1'b0;
        repeat (10) begin
            if (master_rdreq) saw_req = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_req) begin failures++; $display("FAIL busy_dropped_cmd_ran: rdreq got 1 want 0"); end
        checks++; if (acc_q.size() - acc_base != 2) begin failures++; $display("FAIL busy_reads: got %0d want 2", acc_q.size() - acc_base); end
        checks++; if (acc_q[acc_base+1] !== 36'h5010) begin failures++; $display("FAIL busy_addr1: got %h want 5010", acc_q[acc_base+1]); end
        checks++; if (rx_data_q.size() - rx_base != 2) begin failures++; $display("FAIL busy_words: got %0d want 2", rx_data_q.size() - rx_base); end
        checks++; if (fetcher_tag !== 16'h0A0A) begin failures++; $display("FAIL busy_tag: got %h want 0a0a", fetcher_tag); end
    endtask

    task automatic test_reset_mid_issue();
        int acc_base, rx_base;
        bit to, saw_valid;
        logic [35:0] ea;
        ack_delay = 0; out_ready = 1'b0;
        send_cmd(36'h7000, 36'd64, 16'h0006, OPC_FETCH);
        repeat (3) @(posedge clk);
        apply_reset(2);
        stale_cnt++;
        checks++; if (fetcher_command_complete !== 1'b1) begin failures++; $display("FAIL rstmid_complete: got %b want 1", fetcher_command_complete); end
        checks++; if (master_rdreq !== 1'b0) begin failures++; $display("FAIL rstmid_rdreq: got %b want 0", master_rdreq); end
        checks++; if (master_address !== 36'h0) begin failures++; $display("FAIL rstmid_address: got %h want 0", master_address); end
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checks++; if (saw_valid) begin failures++; $display("FAIL rstmid_stale_pushed: out_valid got 1 want 0"); end
        checks++; if (stale_done != stale_cnt) begin failures++; $display("FAIL rstmid_stale_sent: got %0d want %0d", stale_done, stale_cnt); end
        ack_delay = 1; out_ready = 1'b1;
        acc_base = acc_q.size(); rx_base = rx_data_q.size();
        send_cmd(36'h8000, 36'd12, 16'h0007, OPC_FETCH);
        wait_idle(200, to);
        checks++; if (to) begin failures++; $display("FAIL rstmid_timeout: complete got 0 want 1"); end
        checks++; if (rx_data_q.size() - rx_base != 3) begin failures++; $display("FAIL rstmid_words: got %0d want 3", rx_data_q.size() - rx_base); end
        for (int i = 0; i < 3; i++) begin
            ea = 36'h8000 + 36'(16 * i);
            checks++; if (rx_data_q[rx_base+i] !== data_for(ea)) begin failures++; $display("FAIL rstmid_data%0d: got %h want %h", i, rx_data_q[rx_base+i], data_for(ea)); end
        end
        checks++; if (rx_last_q[rx_base+2] !== 1'b1) begin failures++; $display("FAIL rstmid_last: got %b want 1", rx_last_q[rx_base+2]); end
    endtask

`ifdef PIXEL_FETCHER_CHECK_EN
    task automatic test_bad_opcode();
        bit saw_req;
        ack_delay = 1; out_ready = 1'b1;
        send_cmd(36'h9000, 36'd16, 16'h0008, OPC_STORE);
        saw_req = 1'b0;
        repeat (6) begin
            if (master_rdreq) saw_req = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_req) begin failures++; $display("FAIL badop_rdreq: got 1 want 0"); end
        checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL badop_cmd_error: got %b want 1", cmd_error); end
        checks++; if (fetcher_command_complete !== 1'b1) begin failures++; $display("FAIL badop_complete: got %b want 1", fetcher_command_complete); end
        apply_reset(2);
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL badop_clear: got %b want 0", cmd_error); end
    endtask
`endif

    initial begin
        rst                   = 1'b1;
        fetcher_command       = '0;
        fetcher_command_valid = 1'b0;
        master_rdack          = 1'b0;
        master_rdata          = '0;
        master_rvalid         = 1'b0;
        out_ready             = 1'b1;
        test_reset();
        test_basic();
        test_ceil_count();
        test_backpressure();
        test_addr_wrap();
        test_zero_and_busy();
        test_reset_mid_issue();
`ifdef PIXEL_FETCHER_CHECK_EN
        test_bad_opcode();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
